mac_fp32_conv_array: RTL and testbench

//  Multi-lane, elastic successor to the single-lane int->FP32 accumulator converter in the MAC output path.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_fp32_conv_lane.sv | 141 ++++++++++++++
 rtl/mac_fp32_conv_array.sv | 80 ++++++++
 tb/tb_mac_fp32_conv_array.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and FP32 constants for the MAC output-path converters.
package mac_pkg;

    typedef enum logic {
        RND_RNE       = 1'b0,
        RND_HALF_AWAY = 1'b1
    } mac_rnd_mode;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;
    localparam int FP32_MANT_W  = 23;

    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;

endpackage

// File: rtl/mac_fp32_conv_lane.sv
// One lane of the int->FP32 converter: sign/abs, normalise, round/pack.
// Optional flag outputs under MAC_FP32_CONV_FLAGS_EN.
module mac_fp32_conv_lane
    import mac_pkg::*;
#(
    parameter int IN_W  = 34,
    parameter int EXP_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en1,
    input  logic             i_en2,
    input  logic             i_en3,
    input  logic [IN_W-1:0]  i_data,
    input  logic [EXP_W-1:0] i_exp,
    input  mac_rnd_mode      i_rnd_mode,
    output logic [31:0]      o_data
`ifdef MAC_FP32_CONV_FLAGS_EN
    ,
    output logic [2:0]       o_flags
`endif
);

    localparam int AW = IN_W + 1;
    localparam int EW = EXP_W + 8;
    localparam int MW = FP32_MANT_W;
    localparam int LW = $clog2(AW);
    localparam logic signed [EW-1:0] E_MAX = EW'(FP32_EXP_MAX);

    logic                 s1_sign_q;
    logic [AW-1:0]        s1_abs_q;
    logic [EXP_W-1:0]     s1_exp_q;
    mac_rnd_mode          s1_rnd_q;
    logic                 s2_sign_q;
    logic                 s2_zero_q;
    logic [AW-2:0]        s2_frac_q;
    logic signed [EW-1:0] s2_e_q;
    mac_rnd_mode          s2_rnd_q;
    logic [31:0]          s3_data_q;

    logic [AW-1:0]        s1_ext;
    logic [AW-1:0]        s1_abs_d;
    logic [LW-1:0]        msb;
    logic [LW-1:0]        sh;
    logic [AW-2:0]        s2_frac_d;
    logic signed [EW-1:0] s2_e_d;
    logic [MW-1:0]        mant;
    logic                 guard;
    logic                 sticky;
    logic                 rnd_up;
    logic [MW:0]          mant_r;
    logic signed [EW-1:0] e_r;
    logic                 ovf;
    logic                 unf;
    logic [31:0]          s3_data_d;

    // One extra bit keeps abs(-2^(IN_W-1)) exact.
    assign s1_ext   = {i_data[IN_W-1], i_data};
    assign s1_abs_d = s1_ext[AW-1] ? (~s1_ext + AW'(1)) : s1_ext;

    always_comb begin
        msb = '0;
        for (int i = 0; i < AW; i++) begin
            if (s1_abs_q[i]) msb = LW'(i);
        end
    end

    // Shifting the low bits drops the leading one, leaving the fraction.
    assign sh        = LW'(AW - 1) - msb;
    assign s2_frac_d = s1_abs_q[AW-2:0] << sh;
    assign s2_e_d    = EW'(FP32_BIAS) + EW'(msb)
                     + {{8{s1_exp_q[EXP_W-1]}}, s1_exp_q};

    assign mant   = s2_frac_q[AW-2 -: MW];
    assign guard  = s2_frac_q[AW-2-MW];
    assign sticky = |s2_frac_q[AW-3-MW:0];
    assign rnd_up = guard & ((s2_rnd_q == RND_HALF_AWAY) | sticky | mant[0]);
    assign mant_r = {1'b0, mant} + (MW+1)'(rnd_up);
    assign e_r    = s2_e_q + EW'(mant_r[MW]);
    assign ovf    = !s2_zero_q && (e_r >= E_MAX);
    assign unf    = !s2_zero_q && (e_r[EW-1] || (e_r == '0));

    always_comb begin
        s3_data_d = {s2_sign_q, e_r[7:0], mant_r[MW-1:0]};
        unique case (1'b1)
            s2_zero_q: s3_data_d = '0;
            ovf:       s3_data_d = s2_sign_q ? FP32_NEG_INF : FP32_POS_INF;
            unf:       s3_data_d = {s2_sign_q, 31'b0};
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s1_sign_q <= 1'b0;
            s1_abs_q  <= '0;
            s1_exp_q  <= '0;
            s1_rnd_q  <= RND_RNE;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b1;
            s2_frac_q <= '0;
            s2_e_q    <= '0;
            s2_rnd_q  <= RND_RNE;
            s3_data_q <= '0;
        end else begin
            if (i_en1) begin
                s1_sign_q <= i_data[IN_W-1];
                s1_abs_q  <= s1_abs_d;
                s1_exp_q  <= i_exp;
                s1_rnd_q  <= i_rnd_mode;
            end
            if (i_en2) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= ~|s1_abs_q;
                s2_frac_q <= s2_frac_d;
                s2_e_q    <= s2_e_d;
                s2_rnd_q  <= s1_rnd_q;
            end
            if (i_en3) begin
                s3_data_q <= s3_data_d;
            end
        end
    end

    assign o_data = s3_data_q;

`ifdef MAC_FP32_CONV_FLAGS_EN
    logic [2:0] s3_flags_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s3_flags_q <= '0;
        end else if (i_en3) begin
            s3_flags_q <= {ovf, unf, !s2_zero_q && (guard || sticky || unf)};
        end
    end

    assign o_flags = s3_flags_q;
`endif

endmodule

// File: rtl/mac_fp32_conv_array.sv
// Multi-lane elastic int->FP32 converter, 3-stage valid/ready pipe.
// Define MAC_FP32_CONV_FLAGS_EN to add per-lane {ovf, unf, inexact} flags.
module mac_fp32_conv_array
    import mac_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int IN_W      = 34,
    parameter int EXP_W     = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [NUM_LANES*IN_W-1:0] i_data,
    input  logic [EXP_W-1:0]          i_exp,
    input  mac_rnd_mode               i_rnd_mode,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [NUM_LANES*32-1:0]   o_data
`ifdef MAC_FP32_CONV_FLAGS_EN
    ,
    output logic [NUM_LANES*3-1:0]    o_flags
`endif
);

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic ld1, ld2, ld3;

    // A stage may load when the one after it is empty or moving on.
    assign ld3 = !v3_q || i_ready;
    assign ld2 = !v2_q || ld3;
    assign ld1 = !v1_q || ld2;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (ld1) v1_d = i_valid;
        if (ld2) v2_d = v1_q;
        if (ld3) v3_d = v2_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    assign o_ready = ld1;
    assign o_valid = v3_q;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        mac_fp32_conv_lane #(
            .IN_W  (IN_W),
            .EXP_W (EXP_W)
        ) u_lane (
            .i_clk      (i_clk),
            .i_rstn     (i_rstn),
            .i_en1      (ld1 && i_valid),
            .i_en2      (ld2 && v1_q),
            .i_en3      (ld3 && v2_q),
            .i_data     (i_data[k*IN_W +: IN_W]),
            .i_exp      (i_exp),
            .i_rnd_mode (i_rnd_mode),
            .o_data     (o_data[k*32 +: 32])
`ifdef MAC_FP32_CONV_FLAGS_EN
            ,
            .o_flags    (o_flags[k*3 +: 3])
`endif
        );
    end

endmodule

// File: tb/tb_mac_fp32_conv_array.sv
// Self-checking bench for mac_fp32_conv_array against a real-valued model.
// Flag checks are compiled in with MAC_FP32_CONV_FLAGS_EN.
module tb_mac_fp32_conv_array;
    import mac_pkg::*;

    localparam int NL = 8;
    localparam int IW = 34;
    localparam int EW = 8;
    localparam int DW = NL * IW;
    localparam int OW = NL * 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic [EW-1:0] i_exp;
    mac_rnd_mode   i_rnd_mode;
    logic          o_valid;
    logic          i_ready;
    logic [OW-1:0] o_data;
`ifdef MAC_FP32_CONV_FLAGS_EN
    logic [NL*3-1:0] o_flags;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mac_fp32_conv_array #(
        .NUM_LANES (NL),
        .IN_W      (IW),
        .EXP_W     (EW)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_exp      (i_exp),
        .i_rnd_mode (i_rnd_mode),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data)
`ifdef MAC_FP32_CONV_FLAGS_EN
        ,
        .o_flags    (o_flags)
`endif
    );

    // Value-level model: scale to 24 significant bits, round the real remainder.
    function automatic logic [31:0] ref_fp(longint v, int e, bit ha);
        longint a, m;
        int     msb, ex;
        real    q, fr;
        bit     s;
        logic [7:0] eb;
        if (v == 0) return 32'h0;
        s = (v < 0);
        a = s ? -v : v;
        msb = 0;
        while ((a >> (msb + 1)) != 0) msb++;
        q  = real'(a) / (2.0 ** (msb - 23));
        m  = longint'($floor(q));
        fr = q - real'(m);
        if (fr > 0.5 || (fr == 0.5 && (ha || m[0]))) m = m + 1;
        if (m == 64'sd16777216) begin
            m = 64'sd8388608;
            msb++;
        end
        ex = 127 + msb + e;
        if (ex >= 255) return s ? 32'hFF80_0000 : 32'h7F80_0000;
        if (ex <= 0) return {s, 31'b0};
        eb = ex[7:0];
        return {s, eb, m[22:0]};
    endfunction

    function automatic logic [OW-1:0] ref_beat(logic [DW-1:0] d, logic [EW-1:0] e,
                                               mac_rnd_mode md);
        logic [OW-1:0]        r;
        logic signed [IW-1:0] lv;
        logic signed [EW-1:0] es;
        es = e;
        for (int k = 0; k < NL; k++) begin
            lv = d[k*IW +: IW];
            r[k*32 +: 32] = ref_fp(longint'(lv), int'(es), md == RND_HALF_AWAY);
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] rand_lane();
        logic [63:0] r;
        int          sel;
        r   = {$urandom, $urandom};
        sel = int'($urandom_range(0, 7));
        case (sel)
            0: return '0;
            1: return {1'b1, {(IW-1){1'b0}}};
            2: return {1'b0, {(IW-1){1'b1}}};
            3: begin
                r = 64'($urandom_range(0, 8)) - 64'd4;
                return r[IW-1:0];
            end
            4: return {{(IW-25){r[40]}}, r[24:0]};
            default: return r[IW-1:0];
        endcase
    endfunction

    function automatic logic [DW-1:0] lane0_vec(longint v);
        logic [DW-1:0] d;
        d = '0;
        d[IW-1:0] = v[IW-1:0];
        return d;
    endfunction

    task automatic new_beat();
        for (int k = 0; k < NL; k++) i_data[k*IW +: IW] = rand_lane();
        if ($urandom_range(0, 1) == 1) i_exp = 8'($urandom_range(0, 40) - 20);
        else i_exp = 8'($urandom);
        i_rnd_mode = mac_rnd_mode'($urandom_range(0, 1));
    endtask

    // Present one beat to an idle pipe and wait for its result.
    task automatic send_one(input logic [DW-1:0] d, input logic [EW-1:0] e,
                            input mac_rnd_mode md, output logic [OW-1:0] res,
                            output int lat);
        i_data     = d;
        i_exp      = e;
        i_rnd_mode = md;
        i_valid    = 1'b1;
        i_ready    = 1'b1;
        lat        = -1;
        res        = '0;
        @(negedge clk);
        @(posedge clk);
        #1 i_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (o_valid) begin
                lat = c;
                res = o_data;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        i_valid    = 1'b1;
        i_ready    = 1'b0;
        i_data     = {DW{1'b1}};
        i_exp      = 8'd3;
        i_rnd_mode = RND_RNE;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid);
        else n_pass++;
        n_chk++;
        if (o_data !== '0) $display("FAIL reset_data got %h want 0", o_data);
        else n_pass++;
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basics();
        longint        ins[4]  = '{0, 1, 2, -1};
        logic [31:0]   outs[4] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000};
        logic [OW-1:0] res;
        int            lat;
        for (int i = 0; i < 4; i++) begin
            send_one(lane0_vec(ins[i]), 8'd0, RND_RNE, res, lat);
            n_chk++;
            if (res[31:0] !== outs[i])
                $display("FAIL basic_%0d got %h want %h", i, res[31:0], outs[i]);
            else n_pass++;
            n_chk++;
            if (lat != 3) $display("FAIL latency_%0d got %0d want 3", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_rounding();
        longint        ins[4]  = '{64'h100_0001, 64'h100_0001, 64'h1FF_FFFF, 64'h1FF_FFFF};
        mac_rnd_mode   mds[4]  = '{RND_RNE, RND_HALF_AWAY, RND_RNE, RND_HALF_AWAY};
        logic [31:0]   outs[4] = '{32'h4B80_0000, 32'h4B80_0001, 32'h4C00_0000, 32'h4C00_0000};
        logic [OW-1:0] res;
        int            lat;
        for (int i = 0; i < 4; i++) begin
            send_one(lane0_vec(ins[i]), 8'd0, mds[i], res, lat);
            n_chk++;
            if (res[31:0] !== outs[i] || lat != 3)
                $display("FAIL round_%0d got %h lat %0d want %h lat 3",
                         i, res[31:0], lat, outs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [OW-1:0] res;
        int            lat;
        send_one(lane0_vec(2), 8'd127, RND_RNE, res, lat);
        n_chk++;
        if (res[31:0] !== 32'h7F80_0000)
            $display("FAIL sat_ovf got %h want 7f800000", res[31:0]);
        else n_pass++;
`ifdef MAC_FP32_CONV_FLAGS_EN
        n_chk++;
        if (o_flags[2] !== 1'b1) $display("FAIL flag_ovf got %b want 1", o_flags[2]);
        else n_pass++;
`endif
        send_one(lane0_vec(-1), 8'h81, RND_RNE, res, lat);
        n_chk++;
        if (res[31:0] !== 32'h8000_0000)
            $display("FAIL sat_unf got %h want 80000000", res[31:0]);
        else n_pass++;
`ifdef MAC_FP32_CONV_FLAGS_EN
        n_chk++;
        if (o_flags[1:0] !== 2'b11) $display("FAIL flag_unf got %b want 11", o_flags[1:0]);
        else n_pass++;
`endif
    endtask

    // Streams n beats; checks order, hold-under-stall and o_ready occupancy rule.
    task automatic run_stream(input int n, input bit rnd_ready, input bit gaps,
                              input string tag);
        logic [OW-1:0] q[$];
        logic [OW-1:0] exp_v;
        logic [OW-1:0] prev_d;
        bit            hold, acc, outb, exp_rdy;
        int            sent, got, cyc;
        sent    = 0;
        got     = 0;
        cyc     = 0;
        hold    = 1'b0;
        prev_d  = '0;
        i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        new_beat();
        i_valid = 1'b1;
        while (got < n && cyc < n * 20 + 100) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                n_chk++;
                if (o_valid !== 1'b1 || o_data !== prev_d)
                    $display("FAIL %s_hold got v=%b %h want v=1 %h", tag, o_valid, o_data, prev_d);
                else n_pass++;
            end
            exp_rdy = !(q.size() == 3 && !i_ready);
            n_chk++;
            if (o_ready !== exp_rdy)
                $display("FAIL %s_ready got %b want %b (inflight %0d)", tag, o_ready, exp_rdy, q.size());
            else n_pass++;
            acc  = i_valid && o_ready;
            outb = o_valid && i_ready;
            if (outb) begin
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL %s_spurious got %h want no beat", tag, o_data);
                end else begin
                    exp_v = q.pop_front();
                    if (o_data !== exp_v)
                        $display("FAIL %s_beat%0d got %h want %h", tag, got, o_data, exp_v);
                    else n_pass++;
                end
                got++;
            end
            if (acc) q.push_back(ref_beat(i_data, i_exp, i_rnd_mode));
            hold   = o_valid && !i_ready;
            prev_d = o_data;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                i_valid = 1'b0;
            end
            if (!i_valid && sent < n && (!gaps || $urandom_range(0, 3) != 0)) begin
                new_beat();
                i_valid = 1'b1;
            end
            i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_chk++;
        if (got != n || q.size() != 0)
            $display("FAIL %s_count got %0d beats (%0d left) want %0d", tag, got, q.size(), n);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_stream(20, 1'b1, 1'b0, "bp");
        run_stream(40, 1'b0, 1'b0, "full");
    endtask

    task automatic test_reset_midop();
        int seen;
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            new_beat();
            i_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn    = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (o_data !== '0) $display("FAIL midrst_data got %h want 0", o_data);
        else n_pass++;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        n_chk++;
        if (seen != 0) $display("FAIL midrst_flush got %0d outputs want 0", seen);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        run_stream(10000, 1'b1, 1'b1, "rand");
    endtask

    initial begin
        test_reset();
        test_basics();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
